cpu_clock_ctrl: RTL and testbench



---
 rtl/cpu_clk_pkg.sv | 19 +
 rtl/cpu_clock_ctrl_tick_counter.sv | 26 ++
 rtl/cpu_clock_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared types and constants for the CPU clock-enable sequencer.
// State encoding, reset divide ratio and the divide-value sanitiser.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BURST = 2'd3
    } state_t;

    localparam int DEF_DIV = 4;

    // A zero divide ratio would never terminate the phase count.
    function automatic logic [63:0] sanitize_div(input logic [63:0] v);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

endpackage

// File: rtl/cpu_clock_ctrl_tick_counter.sv
// Programmable modulo-N phase counter for the CPU clock enable.
// term is high on the edge where the count wraps.
module tick_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] mod,
    output logic         term
);

    logic [W-1:0] cnt;

    assign term = en && (cnt == mod - W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU execution sequencer: emits a one-cycle cpu_ce pulse per step
// in halted, free-run, single-step and burst modes.
module cpu_clock_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int BURST_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_run,
    input  logic               step_req,
    input  logic               burst_req,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               div_wr,
    input  logic [CNT_W-1:0]   div_val,
    input  logic               halt_req,
    output logic               cpu_ce,
    output logic               busy,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   div_cur,
    output logic [31:0]        ce_count
);

    state_t             st;
    state_t             st_nx;
    logic [CNT_W-1:0]   div_reg;
    logic [BURST_W-1:0] rem;
    logic [BURST_W-1:0] rem_nx;
    logic               ce_nx;
    logic               term;
    logic               tick;
    logic               en;
    logic               clr;
    logic [31:0]        ce_cnt;

    assign en = (st == RUN) || (st == BURST);

    // A divide write restarts the phase, so it also swallows any tick.
    assign tick = term && !div_wr;

    assign clr = div_wr || !((st_nx == RUN) || (st_nx == BURST));

    tick_counter #(
        .W(CNT_W)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .mod (div_reg),
        .term(term)
    );

    always_comb begin
        st_nx  = st;
        rem_nx = rem;
        ce_nx  = 1'b0;
        unique case (st)
            HALT: begin
                if (!halt_req) begin
                    if (mode_run) begin
                        st_nx = RUN;
                    end else if (burst_req && (burst_len != '0)) begin
                        st_nx  = BURST;
                        rem_nx = burst_len;
                    end else if (step_req) begin
                        st_nx = STEP;
                    end
                end
            end
            STEP: begin
                st_nx = HALT;
                ce_nx = !halt_req;
            end
            RUN: begin
                if (halt_req || !mode_run) begin
                    st_nx = HALT;
                end else begin
                    ce_nx = tick;
                end
            end
            BURST: begin
                if (halt_req) begin
                    st_nx  = HALT;
                    rem_nx = '0;
                end else if (tick) begin
                    ce_nx  = 1'b1;
                    rem_nx = rem - BURST_W'(1);
                    if (rem == BURST_W'(1)) begin
                        st_nx = HALT;
                    end
                end
            end
            default: begin
                st_nx = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= HALT;
            rem     <= '0;
            cpu_ce  <= 1'b0;
            ce_cnt  <= '0;
            div_reg <= CNT_W'(sanitize_div(64'(DEFAULT_DIV)));
        end else begin
            st     <= st_nx;
            rem    <= rem_nx;
            cpu_ce <= ce_nx;
            if (ce_nx) begin
                ce_cnt <= ce_cnt + 32'd1;
            end
            if (div_wr) begin
                div_reg <= CNT_W'(sanitize_div(64'(div_val)));
            end
        end
    end

    assign busy     = (st != HALT);
    assign state    = st;
    assign div_cur  = div_reg;
    assign ce_count = ce_cnt;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: a behavioural model predicts
// every cycle's outputs, a monitor compares them against the DUT.
module tb_cpu_clock_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_run = 1'b0;
    logic        step_req = 1'b0;
    logic        burst_req = 1'b0;
    logic [15:0] burst_len = 16'd0;
    logic        div_wr = 1'b0;
    logic [31:0] div_val = 32'd0;
    logic        halt_req = 1'b0;
    logic        cpu_ce;
    logic        busy;
    logic [1:0]  state;
    logic [31:0] div_cur;
    logic [31:0] ce_count;

    cpu_clock_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .mode_run (mode_run),
        .step_req (step_req),
        .burst_req(burst_req),
        .burst_len(burst_len),
        .div_wr   (div_wr),
        .div_val  (div_val),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .busy     (busy),
        .state    (state),
        .div_cur  (div_cur),
        .ce_count (ce_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [1:0]  st;
        logic        busy;
        logic [31:0] div;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    int total_cnt = 0;
    int pass_cnt  = 0;
    bit done      = 1'b0;

    // Model: mode is 0 halted, 1 running, 2 single step, 3 burst.
    // phase counts edges since entry or the last pulse.
    int          m_mode  = 0;
    longint      m_div   = 4;
    longint      m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_count = 0;

    task automatic model_edge();
        bit   ce;
        int   nxt;
        exp_t e;
        ce  = 1'b0;
        nxt = m_mode;
        if (rst) begin
            nxt     = 0;
            m_div   = 4;
            m_phase = 0;
            m_left  = 0;
            m_count = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (halt_req) nxt = 0;
                    else if (mode_run) nxt = 1;
                    else if (burst_req && burst_len != 0) begin
                        nxt    = 3;
                        m_left = int'(burst_len);
                    end else if (step_req) nxt = 2;
                    m_phase = 0;
                end
                2: begin
                    ce  = !halt_req;
                    nxt = 0;
                end
                1: begin
                    if (halt_req || !mode_run) begin
                        nxt     = 0;
                        m_phase = 0;
                    end else if (!div_wr) begin
                        m_phase++;
                        if (m_phase == m_div) begin
                            ce      = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
                default: begin
                    if (halt_req) begin
                        nxt     = 0;
                        m_left  = 0;
                        m_phase = 0;
                    end else if (!div_wr) begin
                        m_phase++;
                        if (m_phase == m_div) begin
                            ce      = 1'b1;
                            m_phase = 0;
                            m_left--;
                            if (m_left == 0) nxt = 0;
                        end
                    end
                end
            endcase
            if (div_wr) begin
                m_div   = (div_val == 0) ? 1 : longint'(div_val);
                m_phase = 0;
            end
            if (ce) m_count = m_count + 32'd1;
        end
        m_mode = nxt;
        e.ce   = ce;
        e.st   = 2'(m_mode);
        e.busy = (m_mode != 0);
        e.div  = 32'(m_div);
        e.cnt  = m_count;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h expected %0h",
                      name, $time, act, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("cpu_ce", 32'(cpu_ce), 32'(e.ce));
                    chk("state", 32'(state), 32'(e.st));
                    chk("busy", 32'(busy), 32'(e.busy));
                    chk("div_cur", div_cur, e.div);
                    chk("ce_count", ce_count, e.cnt);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step_req  = 1'b0;
            burst_req = 1'b0;
            div_wr    = 1'b0;
            rst       = 1'b0;
        end
    endtask

    task automatic pulse_step();
        @(negedge clk);
        step_req = 1'b1;
        idle(1);
    endtask

    task automatic pulse_burst(input int len);
        @(negedge clk);
        burst_req = 1'b1;
        burst_len = 16'(len);
        idle(1);
    endtask

    task automatic pulse_div(input int v);
        @(negedge clk);
        div_wr  = 1'b1;
        div_val = 32'(v);
        idle(1);
    endtask

    initial begin
        idle(2);
        // free run at the reset divide ratio
        mode_run = 1'b1;
        idle(20);
        mode_run = 1'b0;
        idle(3);
        // single step, with a second request landing during STEP
        pulse_step();
        step_req = 1'b1;
        idle(4);
        // short burst at divide 2, then a zero-length burst
        pulse_div(2);
        pulse_burst(3);
        idle(10);
        pulse_burst(0);
        idle(3);
        // divide writes during RUN, including zero and tick-aligned
        pulse_div(4);
        mode_run = 1'b1;
        idle(6);
        pulse_div(0);
        idle(5);
        pulse_div(4);
        idle(2);
        pulse_div(4);
        idle(3);
        pulse_div(4);
        idle(4);
        mode_run = 1'b0;
        idle(2);
        // halt mid-burst with requests held during halt
        pulse_burst(8);
        idle(11);
        halt_req  = 1'b1;
        mode_run  = 1'b1;
        step_req  = 1'b1;
        burst_req = 1'b1;
        burst_len = 16'd5;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        halt_req = 1'b0;
        mode_run = 1'b0;
        idle(2);
        // reset mid-run
        mode_run = 1'b1;
        idle(8);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        mode_run = 1'b0;
        idle(3);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            step_req  = ($urandom_range(0, 5) == 0);
            burst_req = ($urandom_range(0, 9) == 0);
            burst_len = 16'($urandom_range(0, 6));
            div_wr    = ($urandom_range(0, 24) == 0);
            div_val   = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 29) == 0) mode_run = ~mode_run;
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
        end
        idle(3);
        done = 1'b1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
